// File: rtl/reg_write_queue_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_queue_pkg
//
// Shared definitions for the register-file write-back queue:
//   TAG_W / DATA_W      physical tag and result widths
//   N_LANES             execution-unit result lanes accepted per cycle
//   LANE_OFF_W          width able to hold 0..N_LANES (lane offsets and totals)
//   DEPTH_DEFAULT       default FIFO depth (power of two, >= 4)
//   N_DRAIN_DEFAULT     default drain rate (must match register file N_WRITE)
//   wb_entry_t          one queued result {tag, data}
//   laneCount()         number of set lane-valid bits
// -----------------------------------------------------------------------------
package reg_write_queue_pkg;

    localparam int TAG_W           = 6;
    localparam int DATA_W          = 32;
    localparam int N_LANES         = 4;
    localparam int LANE_OFF_W      = $clog2(N_LANES) + 1;
    localparam int DEPTH_DEFAULT   = 8;
    localparam int N_DRAIN_DEFAULT = 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Number of valid lanes in a lane-valid vector.
    function automatic logic [LANE_OFF_W-1:0] laneCount(input logic [0:N_LANES-1] vec);
        logic [LANE_OFF_W-1:0] total;
        total = '0;
        for (int l = 0; l < N_LANES; l++) begin
            total = total + LANE_OFF_W'(vec[l]);
        end
        return total;
    endfunction

endpackage

// File: rtl/reg_write_queue_write_lane_compactor.sv
// -----------------------------------------------------------------------------
// write_lane_compactor
//
// Purely combinational. Turns the per-lane valid vector into the slot offset
// (relative to the FIFO tail) at which each valid lane is stored, so valid
// lanes land in consecutive slots in ascending lane order.
//
// Ports:
//   inVec       [0:N_LANES-1]  lane valid bits (index 0 = lane 0)
//   laneOffset  per lane       number of valid lanes below this lane
//   laneTotal                  number of valid lanes overall
// -----------------------------------------------------------------------------
module write_lane_compactor
    import reg_write_queue_pkg::*;
(
    input  logic [0:N_LANES-1]                   inVec,
    output logic [N_LANES-1:0][LANE_OFF_W-1:0]   laneOffset,
    output logic [LANE_OFF_W-1:0]                laneTotal
);

    logic [LANE_OFF_W-1:0] running;

    // Exclusive prefix popcount: lane l goes to tail + (valid lanes before l).
    always_comb begin
        running    = '0;
        laneOffset = '0;
        for (int l = 0; l < N_LANES; l++) begin
            laneOffset[l] = running;
            running       = running + LANE_OFF_W'(inVec[l]);
        end
    end

    assign laneTotal = laneCount(inVec);

endmodule

// File: rtl/reg_write_queue.sv
// -----------------------------------------------------------------------------
// reg_write_queue
//
// Write-back buffer in front of the 64-entry physical register file. Up to four
// completed results per cycle are compacted into a circular FIFO and drained
// into the register-file write ports, N_DRAIN entries per cycle, in strict
// arrival order.
//
// Handshake: the producer side is a valid/ready pair. inReady is a registered
// function of occupancy (it only says whether a full 4-lane group fits) and
// never depends on inVec. A group is taken at a rising edge exactly when
// inReady=1; when inReady=0 the group is ignored and the producer must hold it.
// The register-file side has no back-pressure: commitAllow/commitVec act as
// write strobes for the values on writeSelect*/writeData*.
//
// Ports:
//   clk                        rising-edge clock
//   reset                      asynchronous, active-low; clears all state
//   en                         global enable; low freezes everything
//   inVec [0:3]                lane valid bits
//   inSelect0..3, inData0..3   per-lane destination tag and result
//   inReady                    a full 4-lane group can be taken this cycle
//   count                      current occupancy
//   commitAllow                register-file write strobe
//   commitVec [0:3]            per-port write enables
//   writeSelect0..3            write addresses
//   writeData0..3              write data
// -----------------------------------------------------------------------------
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int N_DRAIN = N_DRAIN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [0:N_LANES-1]       inVec,
    input  logic [TAG_W-1:0]         inSelect0,
    input  logic [TAG_W-1:0]         inSelect1,
    input  logic [TAG_W-1:0]         inSelect2,
    input  logic [TAG_W-1:0]         inSelect3,
    input  logic [DATA_W-1:0]        inData0,
    input  logic [DATA_W-1:0]        inData1,
    input  logic [DATA_W-1:0]        inData2,
    input  logic [DATA_W-1:0]        inData3,
    output logic                     inReady,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     commitAllow,
    output logic [0:N_LANES-1]       commitVec,
    output logic [TAG_W-1:0]         writeSelect0,
    output logic [TAG_W-1:0]         writeSelect1,
    output logic [TAG_W-1:0]         writeSelect2,
    output logic [TAG_W-1:0]         writeSelect3,
    output logic [DATA_W-1:0]        writeData0,
    output logic [DATA_W-1:0]        writeData1,
    output logic [DATA_W-1:0]        writeData2,
    output logic [DATA_W-1:0]        writeData3
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(N_DRAIN);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(N_LANES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   occupancy;

    logic               commitAllowReg;
    logic [0:N_LANES-1] commitVecReg;
    logic [TAG_W-1:0]   selReg  [N_LANES];
    logic [DATA_W-1:0]  dataReg [N_LANES];

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    wb_entry_t                              laneEntry [N_LANES];
    logic [N_LANES-1:0][LANE_OFF_W-1:0]     laneOffset;
    logic [LANE_OFF_W-1:0]                  laneTotal;
    logic [LANE_OFF_W-1:0]                  enqTotal;
    logic [PTR_W-1:0]                       wrIdx [N_LANES];
    logic [CNT_W-1:0]                       freeSlots;

    always_comb begin
        laneEntry[0] = '{tag: inSelect0, data: inData0};
        laneEntry[1] = '{tag: inSelect1, data: inData1};
        laneEntry[2] = '{tag: inSelect2, data: inData2};
        laneEntry[3] = '{tag: inSelect3, data: inData3};
    end

    write_lane_compactor u_compactor (
        .inVec      (inVec),
        .laneOffset (laneOffset),
        .laneTotal  (laneTotal)
    );

    assign freeSlots = DEPTH_C - occupancy;

    // Gated by reset so the producer sees "not ready" while the queue is held
    // in reset, even though occupancy is already zero.
    assign inReady  = reset && en && (freeSlots >= LANES_C);
    assign enqTotal = inReady ? laneTotal : '0;

    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            wrIdx[l] = tailPtr + PTR_W'(laneOffset[l]);
        end
    end

    // ------------------------------------------------------------------
    // Drain side
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] drainK;
    logic [PTR_W-1:0] rdIdx [N_LANES];

    // drainK uses occupancy before the edge, so entries written at this edge
    // are never drained at the same edge.
    assign drainK = (occupancy < DRAIN_C) ? occupancy : DRAIN_C;

    always_comb begin
        for (int p = 0; p < N_LANES; p++) begin
            rdIdx[p] = headPtr + PTR_W'(p);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: no reset needed, validity is carried by the pointers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int l = 0; l < N_LANES; l++) begin
            if (inReady && inVec[l]) begin
                entries[wrIdx[l]] <= laneEntry[l];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else if (en) begin
            headPtr   <= headPtr + PTR_W'(drainK);
            tailPtr   <= tailPtr + PTR_W'(enqTotal);
            occupancy <= occupancy + CNT_W'(enqTotal) - drainK;
        end
    end

    // ------------------------------------------------------------------
    // Write-port output registers. Ports at or beyond drainK keep their
    // previous address/data; only their enable drops. Older entries sit on
    // lower ports, so a same-tag pair in one group lets the later result win
    // at the register file (higher port has priority there).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commitAllowReg <= 1'b0;
            commitVecReg   <= '0;
            for (int p = 0; p < N_LANES; p++) begin
                selReg[p]  <= '0;
                dataReg[p] <= '0;
            end
        end else if (en) begin
            commitAllowReg <= (drainK != '0);
            for (int p = 0; p < N_LANES; p++) begin
                commitVecReg[p] <= (CNT_W'(p) < drainK);
                if (CNT_W'(p) < drainK) begin
                    selReg[p]  <= entries[rdIdx[p]].tag;
                    dataReg[p] <= entries[rdIdx[p]].data;
                end
            end
        end
    end

    assign count        = occupancy;
    assign commitAllow  = commitAllowReg;
    assign commitVec    = commitVecReg;
    assign writeSelect0 = selReg[0];
    assign writeSelect1 = selReg[1];
    assign writeSelect2 = selReg[2];
    assign writeSelect3 = selReg[3];
    assign writeData0   = dataReg[0];
    assign writeData1   = dataReg[1];
    assign writeData2   = dataReg[2];
    assign writeData3   = dataReg[3];

endmodule
